// File: rtl/result_prev_element_reader.sv
// Snapshot-and-stream reader for the previous-result holding register.
// Optional replay of the held snapshot is enabled by defining RESULT_PREV_READER_REPLAY_EN.
module result_prev_element_reader #(
    parameter int number_of_equations_per_cluster = 9,
    parameter int element_width                   = 32,
    parameter int index_width                     = 4
) (
    input  logic                                                      clk,
    input  logic                                                      rst,
    input  logic                                                      start,
`ifdef RESULT_PREV_READER_REPLAY_EN
    input  logic                                                      replay,
`endif
    input  logic [element_width*number_of_equations_per_cluster-1:0] result_data,
    output logic                                                      busy,
    output logic                                                      out_valid,
    input  logic                                                      out_ready,
    output logic [element_width-1:0]                                  out_data,
    output logic [index_width-1:0]                                    out_index,
    output logic                                                      out_last,
    output logic                                                      done,
    output logic                                                      overrun
);

    // state  | meaning
    // IDLE   | no snapshot being streamed; waiting for start (or replay)
    // STREAM | presenting snapshot element[idx_q] with out_valid high

    localparam int VEC_W = element_width * number_of_equations_per_cluster;
    localparam logic [index_width-1:0] LAST_IDX = index_width'(number_of_equations_per_cluster - 1);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t                   state_q, state_d;
    logic [VEC_W-1:0]         snap_q, snap_d;
    logic [index_width-1:0]   idx_q, idx_d;
    logic                     done_q, done_d;
    logic                     ovr_q, ovr_d;
    logic                     replay_req;
    logic                     xfer;
    logic                     last_xfer;
    logic [element_width-1:0] elem;

`ifdef RESULT_PREV_READER_REPLAY_EN
    assign replay_req = replay;
`else
    assign replay_req = 1'b0;
`endif

    assign xfer      = (state_q == STREAM) && out_ready;
    assign last_xfer = xfer && (idx_q == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            snap_q  <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        ovr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    snap_d  = result_data;
                    idx_d   = '0;
                    state_d = STREAM;
                end else if (replay_req) begin
                    idx_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (last_xfer) begin
                    done_d = 1'b1;
                    idx_d  = '0;
                    // a request coinciding with the final transfer chains the next stream without a gap
                    if (start) begin
                        snap_d = result_data;
                    end else if (!replay_req) begin
                        state_d = IDLE;
                    end
                end else begin
                    if (xfer) begin
                        idx_d = idx_q + 1'b1;
                    end
                    if (start || replay_req) begin
                        ovr_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        elem = '0;
        for (int k = 0; k < number_of_equations_per_cluster; k++) begin
            if (idx_q == index_width'(k)) begin
                elem = snap_q[k*element_width +: element_width];
            end
        end
    end

    assign busy      = (state_q == STREAM);
    assign out_valid = busy;
    assign out_data  = busy ? elem : '0;
    assign out_index = idx_q;
    assign out_last  = busy && (idx_q == LAST_IDX);
    assign done      = done_q;
    assign overrun   = ovr_q;

endmodule

// File: doc/result_prev_element_reader.md
Name: result_prev_element_reader

Overview:
- Consumer side of the previous-result holding register.
- Takes a snapshot of the packed per-cluster result vector (number_of_equations_per_cluster elements of element_width bits) on a start pulse.
- Streams the snapshot out one element per handshake over a valid/ready interface to the downstream element-serial datapath.
- Frees the holding register for its next write as soon as the snapshot is taken.

Parameters:
- number_of_equations_per_cluster, 9, elements per packed vector (>=1).
- element_width, 32, bits per element.
- index_width, 4, width of the element index output; must satisfy 2^index_width >= number_of_equations_per_cluster.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  single-cycle request to snapshot result_data and begin streaming.
- result_data  input  element_width*number_of_equations_per_cluster  packed vector; element k is bits [k*element_width +: element_width].
- busy  output  1  high while a snapshot is being streamed.
- out_valid  output  1  out_data/out_index/out_last are valid.
- out_ready  input  1  downstream accepts the current element.
- out_data  output  element_width  current element.
- out_index  output  index_width  index k of the current element.
- out_last  output  1  current element is element number_of_equations_per_cluster-1.
- done  output  1  one-cycle pulse after the last element transfers.
- overrun  output  1  one-cycle pulse when start is rejected.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high (rst).
- Reset values: state IDLE, snapshot register 0, index 0; busy, out_valid, out_last, done, overrun all 0; out_data 0, out_index 0. Reset asserted mid-stream aborts immediately; no done pulse.
- States: IDLE, STREAM.
- IDLE, start=1 at edge T:
  - snapshot <= result_data, index <= 0, go to STREAM.
  - From T+1: busy=1, out_valid=1, out_data = element 0, out_index = 0.
  - Latency from start to first valid element: 1 cycle.
- STREAM:
  - out_valid=1 continuously.
  - out_data = snapshot element[index], out_last = (index == number_of_equations_per_cluster-1).
- Transfer = out_valid & out_ready at a rising edge.
  - Not last: index increments by 1.
  - Last: go to IDLE. Next cycle busy=0, out_valid=0, done=1 for exactly one cycle, index reset to 0.
- Stall: while out_valid & !out_ready, out_data, out_index and out_last are held stable.
- start in STREAM without a last-element transfer in the same cycle: ignored, snapshot unchanged, overrun=1 for the next cycle.
- start in the same cycle as the last-element transfer (back-to-back):
  - New snapshot taken, index <= 0, stay in STREAM.
  - Next cycle: out_valid stays 1 with new element 0, done=1 pulses, busy stays 1, no overrun.
- result_data is sampled only on an accepted start. Later changes to result_data, including writes to the holding register, do not affect the stream in progress.
- number_of_equations_per_cluster=1: element 0 has out_last=1; one transfer ends the stream.
- Index wrap: the index never exceeds number_of_equations_per_cluster-1; there is no modulo wrap beyond it.

Optional Feature:
- Macro: RESULT_PREV_READER_REPLAY_EN.
- Defined:
  - Adds input port replay (1 bit).
  - replay=1 in IDLE with start=0 restarts streaming from element 0 of the existing snapshot, with the same 1-cycle latency.
  - start has priority over replay when both are high.
  - replay in STREAM is treated like a rejected start (overrun pulse), except in the last-transfer cycle, where it restarts the old snapshot back-to-back.
- Not defined: no replay port; every stream requires start and a fresh snapshot.

Test Plan:
- Basic stream: result_data = elements 0x00000001..0x00000009, start for 1 cycle, out_ready=1 -> out_data 1..9 on 9 consecutive cycles starting 1 cycle after start; out_index 0..8; out_last only with 9; done one cycle after element 9; busy high for 9 cycles.
- Backpressure: same vector, out_ready low on the cycles presenting elements 3 and 7 (2 cycles each) -> values held stable while stalled; sequence still 1..9; total 13 valid cycles.
- Overrun and snapshot isolation: start, then change result_data to all 0xFFFFFFFF and pulse start at element 4 -> overrun pulses once; stream still outputs the original 1..9.
- Back-to-back: second vector 0x10..0x18, start coincident with the element-9 transfer -> out_valid never drops; 0x10 follows 9 directly; done pulses once between the streams; no overrun.
- Reset mid-stream: assert rst asynchronously (between edges) while element 5 is presented -> out_valid, busy and done go to 0 immediately; no done pulse; a later start streams a new vector from index 0.
- Replay (RESULT_PREV_READER_REPLAY_EN defined): after the basic stream completes, pulse replay with result_data changed -> 1..9 streamed again from the old snapshot.
